// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: sequences the five-stage pipeline around data hazards,
// PC redirects (branch/call/ret) and multi-cycle data-memory accesses.
// Outputs are Mealy: decoded from the registered state plus the current inputs.
// Optional feature macro: PIPE_CTRL_STATS_EN builds the saturating stall-cycle
// counter; without it stall_cycles is tied to zero and no counter flops exist.
module pipeline_stall_ctrl #(
    parameter int PC_WAIT_MAX = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_hazard,
    input  logic             pc_hazard,
    input  logic             pc_update,
    input  logic             mem_busy,
    output logic             pc_we,
    output logic             pc_sel_target,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       ctrl_state,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DSTALL   = 2'd1,
        PC_WAIT  = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    // Last wait-count value before the redirect wait gives up.
    localparam logic [7:0] WCNT_LAST = 8'(PC_WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       upd_pend_q, upd_pend_d;
    logic       timeout_q, timeout_d;
    logic       run_rules;

    // Decode outputs and next state from the current state and hazard inputs.
    always_comb begin
        pc_we         = 1'b1;
        pc_sel_target = 1'b0;
        ifid_we       = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        pipe_freeze   = 1'b0;
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        upd_pend_d    = 1'b0;
        timeout_d     = timeout_q;
        run_rules     = 1'b0;

        case (state_q)
            DSTALL: begin
                if (data_hazard && !mem_busy) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    pipe_freeze = 1'b1;
                end else begin
                    run_rules = 1'b1;
                end
            end
            PC_WAIT: begin
                pc_we       = 1'b0;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                if (mem_busy) begin
                    // Back end frozen: the wait does not age, and a target that
                    // arrives now is remembered until the freeze lifts.
                    pipe_freeze = 1'b1;
                    idex_bubble = 1'b0;
                    upd_pend_d  = upd_pend_q | pc_update;
                end else if (pc_update || upd_pend_q) begin
                    pc_we         = 1'b1;
                    pc_sel_target = 1'b1;
                    state_d       = RUN;
                end else if (wcnt_q == WCNT_LAST) begin
                    // Target never came: fall through sequentially and flag it.
                    timeout_d = 1'b1;
                    pc_we     = 1'b1;
                    state_d   = RUN;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            default: run_rules = 1'b1;
        endcase

        if (run_rules) begin
            if (mem_busy) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                pipe_freeze = 1'b1;
                state_d     = MEM_WAIT;
            end else if (pc_hazard) begin
                pc_we      = 1'b0;
                ifid_flush = 1'b1;
                state_d    = PC_WAIT;
                wcnt_d     = 8'd0;
            end else if (data_hazard) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                state_d     = DSTALL;
            end else begin
                state_d = RUN;
            end
        end

        // While in reset the pipeline is held with NOPs in IF/ID and ID/EX.
        if (rst) begin
            pc_we         = 1'b0;
            pc_sel_target = 1'b0;
            ifid_we       = 1'b0;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            pipe_freeze   = 1'b0;
        end
    end

    // Register control state, wait counter, pending-update and sticky timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wcnt_q     <= 8'd0;
            upd_pend_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            upd_pend_q <= upd_pend_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ctrl_state  = state_q;
    assign timeout_err = timeout_q;

`ifdef PIPE_CTRL_STATS_EN
    logic [CNT_W-1:0] stall_q;

    // Count cycles in which the PC is held, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!pc_we && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios followed by
// randomized hazard traffic, all compared against a cycle-level action model.
module tb_pipeline_stall_ctrl;

    localparam int MAXW = 4;
    localparam int CW   = 4;

    // Model actions: what the controller does to the pipeline in one cycle.
    localparam int A_GO      = 0;
    localparam int A_FREEZE  = 1;
    localparam int A_FLUSH   = 2;
    localparam int A_DSTALL  = 3;
    localparam int A_WAIT    = 4;
    localparam int A_WAITF   = 5;
    localparam int A_TARGET  = 6;
    localparam int A_TIMEOUT = 7;
    localparam int A_RST     = 8;

    logic          clk = 1'b0;
    logic          rst, data_hazard, pc_hazard, pc_update, mem_busy;
    logic          pc_we, pc_sel_target, ifid_we, ifid_flush, idex_bubble, pipe_freeze;
    logic [1:0]    ctrl_state;
    logic          timeout_err;
    logic [CW-1:0] stall_cycles;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.PC_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .data_hazard(data_hazard), .pc_hazard(pc_hazard),
        .pc_update(pc_update), .mem_busy(mem_busy), .pc_we(pc_we),
        .pc_sel_target(pc_sel_target), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .ctrl_state(ctrl_state),
        .timeout_err(timeout_err), .stall_cycles(stall_cycles)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: mode 0 run, 1 data stall, 2 waiting for target, 3 memory wait.
    int m_mode   = 0;
    int m_waited = 0;
    bit m_pend   = 1'b0;
    bit m_err    = 1'b0;
    int m_stall  = 0;
    bit m_known  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_action(input logic dh, input logic ph, input logic pu, input logic mb);
        if (m_mode == 1 && dh && !mb) return A_DSTALL;
        if (m_mode == 3 && mb) return A_FREEZE;
        if (m_mode == 2) begin
            if (mb) return A_WAITF;
            if (pu || m_pend) return A_TARGET;
            if (m_waited == MAXW - 1) return A_TIMEOUT;
            return A_WAIT;
        end
        if (mb) return A_FREEZE;
        if (ph) return A_FLUSH;
        if (dh) return A_DSTALL;
        return A_GO;
    endfunction

    // {pc_we, pc_sel_target, ifid_we, ifid_flush, idex_bubble, pipe_freeze}
    function automatic logic [5:0] act_outputs(input int act);
        case (act)
            A_GO:      return 6'b101000;
            A_FREEZE:  return 6'b000001;
            A_FLUSH:   return 6'b001100;
            A_DSTALL:  return 6'b000010;
            A_WAIT:    return 6'b001110;
            A_WAITF:   return 6'b001101;
            A_TARGET:  return 6'b111110;
            A_TIMEOUT: return 6'b101110;
            default:   return 6'b000110;
        endcase
    endfunction

    function automatic int exp_stat();
`ifdef PIPE_CTRL_STATS_EN
        return m_stall;
`else
        return 0;
`endif
    endfunction

    task automatic advance(input int act, input logic pu);
        logic [5:0] o;
        if (act == A_RST) begin
            m_mode = 0; m_waited = 0; m_pend = 1'b0; m_err = 1'b0; m_stall = 0; m_known = 1'b1;
            return;
        end
        o = act_outputs(act);
        if (!o[5] && m_stall < (1 << CW) - 1) m_stall++;
        case (act)
            A_GO:      m_mode = 0;
            A_FREEZE:  m_mode = 3;
            A_FLUSH:   begin m_mode = 2; m_waited = 0; end
            A_DSTALL:  m_mode = 1;
            A_WAIT:    m_waited++;
            A_WAITF:   m_pend = m_pend | pu;
            A_TARGET:  begin m_mode = 0; m_pend = 1'b0; end
            A_TIMEOUT: begin m_mode = 0; m_err = 1'b1; end
            default:   ;
        endcase
    endtask

    // One clock cycle: apply inputs, check at the falling edge, advance model.
    task automatic step(input logic r, input logic dh, input logic ph, input logic pu, input logic mb);
        int         act;
        logic [5:0] exp_o;
        logic [5:0] got_o;
        rst = r; data_hazard = dh; pc_hazard = ph; pc_update = pu; mem_busy = mb;
        @(negedge clk);
        act   = r ? A_RST : pick_action(dh, ph, pu, mb);
        exp_o = act_outputs(act);
        got_o = {pc_we, pc_sel_target, ifid_we, ifid_flush, idex_bubble, pipe_freeze};
        chk("outputs", 32'(got_o), 32'(exp_o));
        if (m_known) begin
            chk("ctrl_state", 32'(ctrl_state), 32'(m_mode));
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
            chk("stall_cycles", 32'(stall_cycles), 32'(exp_stat()));
        end
        @(posedge clk);
        advance(act, pu);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; data_hazard = 1'b0; pc_hazard = 1'b0; pc_update = 1'b0; mem_busy = 1'b0;
        #1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_state", 32'(ctrl_state), 32'd0);
        chk("reset_timeout", 32'(timeout_err), 32'd0);
        idle(2);

        // Data stall for three cycles, then resume.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("dstall_state", 32'(ctrl_state), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("dstall_resume_state", 32'(ctrl_state), 32'd0);

        // Branch resolved two cycles after the hazard.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("branch_back_to_run", 32'(ctrl_state), 32'd0);
        chk("branch_no_timeout", 32'(timeout_err), 32'd0);
        idle(1);

        // Memory stall across a pending target update.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pend_still_waiting", 32'(ctrl_state), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pend_taken", 32'(ctrl_state), 32'd0);

        // Priority: memory dominates, then the PC hazard wins over data hazard.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("prio_memwait", 32'(ctrl_state), 32'd3);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("prio_pcwait", 32'(ctrl_state), 32'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Timeout: no target ever arrives.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(MAXW);
        chk("timeout_set", 32'(timeout_err), 32'd1);
        chk("timeout_run", 32'(ctrl_state), 32'd0);
        idle(3);
        chk("timeout_sticky", 32'(timeout_err), 32'd1);

        // Reset in the middle of a redirect wait, then a five-cycle data stall.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_mid_state", 32'(ctrl_state), 32'd0);
        chk("rst_mid_timeout", 32'(timeout_err), 32'd0);
        chk("rst_mid_stats", 32'(stall_cycles), 32'd0);
        idle(1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_CTRL_STATS_EN
        chk("stats_five", 32'(stall_cycles), 32'd5);
`else
        chk("stats_off", 32'(stall_cycles), 32'd0);
`endif
        idle(1);

        // Randomized traffic, long enough to saturate the small stats counter.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 20));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Sequences the five-stage CPU pipeline in response to hazard and memory-stall indications. It consumes the hazard unit's `data_hazard` and `PC_hazard` flags, the PC-update completion pulse and the data-memory busy flag. From these it drives the PC / IF-ID / ID-EX / back-end register enables, flushes and bubbles. It also owns the wait-for-target sequence after branch/call/ret and flags a PC-update timeout.

## Interface
- `PC_WAIT_MAX`, default 8: cycles allowed in PC_WAIT before timeout; legal range 2..255.
- `CNT_W`, default 16: width of the stall statistics counter.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `data_hazard`  in  1  RAW hazard on the instruction in ID.
- `pc_hazard`  in  1  branch/call/ret in ID; next PC unknown.
- `pc_update`  in  1  single-cycle pulse: target PC valid.
- `mem_busy`  in  1  data memory multi-cycle access in progress.
- `pc_we`  out  1  PC register write enable.
- `pc_sel_target`  out  1  PC mux selects the computed target.
- `ifid_we`  out  1  IF/ID register write enable.
- `ifid_flush`  out  1  load NOP into IF/ID.
- `idex_bubble`  out  1  load NOP (all write enables 0) into ID/EX.
- `pipe_freeze`  out  1  hold ID/EX, EX/MEM, MEM/WB.
- `ctrl_state`  out  2  current state encoding (RUN=0, DSTALL=1, PC_WAIT=2, MEM_WAIT=3).
- `timeout_err`  out  1  sticky flag: PC_WAIT expired without `pc_update`.
- `stall_cycles`  out  CNT_W  saturating count of cycles with `pc_we=0`.

## Operation
- Registered state, wait counter `wcnt` (8 bits) and `upd_pend` flag. Outputs are combinational from state plus inputs (Mealy).
- Default outputs: `pc_we=1`, `ifid_we=1`, all other outputs 0.
- **RUN rules.** Evaluate in this order; the first match wins.
  - `mem_busy`: `pc_we=0`, `ifid_we=0`, `pipe_freeze=1`. Next state MEM_WAIT.
  - `pc_hazard`: `pc_we=0`, `ifid_flush=1`. Next state PC_WAIT, `wcnt←0`.
  - `data_hazard`: `pc_we=0`, `ifid_we=0`, `idex_bubble=1`. Next state DSTALL.
  - Otherwise: default outputs, stay in RUN.
- **DSTALL.** While `data_hazard=1` and `mem_busy=0`: same outputs as the data-stall case, stay in DSTALL. Otherwise apply the RUN rules in this cycle, including transitions.
- **MEM_WAIT.** While `mem_busy=1`: `pc_we=0`, `ifid_we=0`, `pipe_freeze=1`. When `mem_busy=0`: apply the RUN rules in this cycle.
- **PC_WAIT.**
  - Base outputs: `pc_we=0`, `ifid_flush=1`, `idex_bubble=1`.
  - Let `upd = pc_update | upd_pend`.
  - If `mem_busy=1`: base outputs plus `pipe_freeze=1` and `idex_bubble=0`. Hold `wcnt`. A `pc_update` pulse in this cycle sets `upd_pend`.
  - Else if `upd=1`: `pc_we=1`, `pc_sel_target=1`, `ifid_flush=1`. Clear `upd_pend`, next state RUN.
  - Else if `wcnt==PC_WAIT_MAX-1`: set `timeout_err`, `pc_we=1`, `pc_sel_target=0` (sequential fall-through). Next state RUN.
  - Else: `wcnt←wcnt+1`.
- `pc_update` outside PC_WAIT is ignored, and `upd_pend` stays 0.
- `timeout_err` clears only on `rst`.

## Timing
- **Reset.** While `rst=1`:
  - Outputs: `pc_we=0`, `ifid_we=0`, `ifid_flush=1`, `idex_bubble=1`, `pipe_freeze=0`, `pc_sel_target=0`.
  - On the next edge: state RUN, `wcnt=0`, `upd_pend=0`, `timeout_err=0`, `stall_cycles=0`.
- Reset mid-operation abandons any stall or wait; the first cycle after reset is RUN.
- **Data stall.** Latency is 0 cycles: enables drop in the same cycle `data_hazard` rises. The pipeline resumes in the cycle `data_hazard` falls.
- **PC redirect.** The redirect is written on the edge that ends the cycle in which `pc_update` (or the pending flag) is seen.
  - Minimum PC_WAIT residency is 1 cycle.
  - Maximum residency is `PC_WAIT_MAX` non-frozen cycles.
- **Simultaneous events.** `mem_busy` always dominates. `pc_hazard` dominates `data_hazard`.

## Configuration
- `PIPE_CTRL_STATS_EN` defined: `stall_cycles` increments on every non-reset cycle with `pc_we=0`. It saturates at all-ones and clears on `rst`.
- Not defined: `stall_cycles` is constant 0 and no counter flops are built.

## Test plan
- **Data stall.** Hold `data_hazard=1` for 3 cycles → `pc_we=0`, `ifid_we=0`, `idex_bubble=1` for exactly 3 cycles, `ctrl_state=1` for the last 2. Cycle 4: `pc_we=1`, state 0.
- **Branch.** Pulse `pc_hazard`, then `pc_update` 2 cycles later → 1 RUN flush cycle, 2 PC_WAIT cycles with the second showing `pc_we=1` and `pc_sel_target=1`, then RUN. `timeout_err=0`.
- **Timeout.** Set `PC_WAIT_MAX=4`, pulse `pc_hazard`, no `pc_update` → after 4 PC_WAIT cycles: `timeout_err=1`, `pc_we=1`, `pc_sel_target=0`. `timeout_err` stays 1 until `rst`.
- **Memory stall over pending update.** Enter PC_WAIT, raise `mem_busy` for 3 cycles with `pc_update` pulsed in the second → `pipe_freeze=1` for 3 cycles, `wcnt` held. The first cycle with `mem_busy=0` gives `pc_sel_target=1`.
- **Priority.** Assert `mem_busy`, `pc_hazard` and `data_hazard` together in RUN → `pipe_freeze=1`, state MEM_WAIT. On `mem_busy` dropping with `pc_hazard` still high → transition to PC_WAIT.
- **Reset mid-wait.** Assert `rst` in PC_WAIT → reset output values shown. After release: RUN, `stall_cycles=0`. With `PIPE_CTRL_STATS_EN` defined, a following 5-cycle data stall gives `stall_cycles=5`.
